// File: rtl/pe_pixel_loader.sv
// Serial RGB pixel loader for the background-removal pe: packs NUM_PIXELS
// pixels into flat lane vectors and computes per-channel batch means.
module pe_pixel_loader #(
  parameter int NUM_PIXELS  = 4,
  parameter int LOG2_PIXELS = 2
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Pix_Valid,
  output logic                    Pix_Ready,
  input  logic [7:0]              Pix_R,
  input  logic [7:0]              Pix_G,
  input  logic [7:0]              Pix_B,
  input  logic                    Batch_Ack,
  output logic                    Batch_Valid,
  output logic [8*NUM_PIXELS-1:0] red_in,
  output logic [8*NUM_PIXELS-1:0] green_in,
  output logic [8*NUM_PIXELS-1:0] blue_in,
  output logic [7:0]              red_exp,
  output logic [7:0]              green_exp,
  output logic [7:0]              blue_exp,
  output logic                    Ql,
  output logic                    Qc,
  output logic                    Qd
);

  localparam int SW = 8 + LOG2_PIXELS;

  localparam logic [2:0] QL = 3'b001;
  localparam logic [2:0] QC = 3'b010;
  localparam logic [2:0] QD = 3'b100;

  logic [2:0]             state;
  logic [LOG2_PIXELS-1:0] cnt;
  logic [SW-1:0]          sum_r;
  logic [SW-1:0]          sum_g;
  logic [SW-1:0]          sum_b;
  logic                   accept;

  // One-hot state bits double as the handshake outputs.
  assign Ql          = state[0];
  assign Qc          = state[1];
  assign Qd          = state[2];
  assign Pix_Ready   = state[0];
  assign Batch_Valid = state[2];
  assign accept      = Pix_Valid && Pix_Ready;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= QL;
      cnt       <= '0;
      sum_r     <= '0;
      sum_g     <= '0;
      sum_b     <= '0;
      red_in    <= '0;
      green_in  <= '0;
      blue_in   <= '0;
      red_exp   <= '0;
      green_exp <= '0;
      blue_exp  <= '0;
    end else begin
      case (state)
        QL: begin
          if (accept) begin
            red_in[{cnt, 3'b000} +: 8]   <= Pix_R;
            green_in[{cnt, 3'b000} +: 8] <= Pix_G;
            blue_in[{cnt, 3'b000} +: 8]  <= Pix_B;
            sum_r <= sum_r + {{LOG2_PIXELS{1'b0}}, Pix_R};
            sum_g <= sum_g + {{LOG2_PIXELS{1'b0}}, Pix_G};
            sum_b <= sum_b + {{LOG2_PIXELS{1'b0}}, Pix_B};
            // Counter width equals log2 of the batch size, so it wraps to 0 here.
            cnt   <= cnt + 1'b1;
            if (cnt == LOG2_PIXELS'(NUM_PIXELS - 1))
              state <= QC;
          end
        end
        QC: begin
          red_exp   <= sum_r[SW-1:LOG2_PIXELS];
          green_exp <= sum_g[SW-1:LOG2_PIXELS];
          blue_exp  <= sum_b[SW-1:LOG2_PIXELS];
          state     <= QD;
        end
        QD: begin
          if (Batch_Ack) begin
            state <= QL;
            sum_r <= '0;
            sum_g <= '0;
            sum_b <= '0;
          end
        end
        default: state <= QL;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_pixel_loader.sv
// Self-checking bench for pe_pixel_loader: table-driven first batch, directed
// corner-case sequences and randomized traffic against a queue-based model.
module tb_pe_pixel_loader;
  localparam int NP = 4;
  localparam int LP = 2;
  localparam int M_LOAD = 0;
  localparam int M_CALC = 1;
  localparam int M_DONE = 2;

  logic            Clk = 1'b0;
  logic            Reset = 1'b0;
  logic            Pix_Valid = 1'b0;
  logic            Pix_Ready;
  logic [7:0]      Pix_R = '0;
  logic [7:0]      Pix_G = '0;
  logic [7:0]      Pix_B = '0;
  logic            Batch_Ack = 1'b0;
  logic            Batch_Valid;
  logic [8*NP-1:0] red_in, green_in, blue_in;
  logic [7:0]      red_exp, green_exp, blue_exp;
  logic            Ql, Qc, Qd;

  pe_pixel_loader #(.NUM_PIXELS(NP), .LOG2_PIXELS(LP)) dut (
    .Clk(Clk), .Reset(Reset), .Pix_Valid(Pix_Valid), .Pix_Ready(Pix_Ready),
    .Pix_R(Pix_R), .Pix_G(Pix_G), .Pix_B(Pix_B), .Batch_Ack(Batch_Ack),
    .Batch_Valid(Batch_Valid), .red_in(red_in), .green_in(green_in),
    .blue_in(blue_in), .red_exp(red_exp), .green_exp(green_exp),
    .blue_exp(blue_exp), .Ql(Ql), .Qc(Qc), .Qd(Qd)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: accepted pixels of the current batch in queues, lanes
  // and means held as the values pe should see.
  int              phase;
  int              q_r[$], q_g[$], q_b[$];
  logic [8*NP-1:0] m_red, m_green, m_blue;
  logic [7:0]      me_r, me_g, me_b;

  typedef struct {
    logic       pv;
    logic [7:0] r, g, b;
    logic       ack;
    logic       rdy;
    logic       vld;
    logic [2:0] q;   // {Qd,Qc,Ql} after the edge
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    phase = M_LOAD;
    q_r.delete(); q_g.delete(); q_b.delete();
    m_red = '0; m_green = '0; m_blue = '0;
    me_r = '0; me_g = '0; me_b = '0;
  endtask

  function automatic logic [7:0] mean(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return 8'(s / NP);
  endfunction

  task automatic model_edge();
    case (phase)
      M_LOAD: if (Pix_Valid) begin
        m_red[8*q_r.size() +: 8]   = Pix_R;
        m_green[8*q_r.size() +: 8] = Pix_G;
        m_blue[8*q_r.size() +: 8]  = Pix_B;
        q_r.push_back(int'(Pix_R)); q_g.push_back(int'(Pix_G)); q_b.push_back(int'(Pix_B));
        if (q_r.size() == NP) phase = M_CALC;
      end
      M_CALC: begin
        me_r = mean(q_r); me_g = mean(q_g); me_b = mean(q_b);
        q_r.delete(); q_g.delete(); q_b.delete();
        phase = M_DONE;
      end
      default: if (Batch_Ack) phase = M_LOAD;
    endcase
  endtask

  task automatic check_model(input string tag);
    logic [2:0] qs;
    qs = (phase == M_LOAD) ? 3'b001 : (phase == M_CALC) ? 3'b010 : 3'b100;
    chk({tag, ".ready"}, 32'(Pix_Ready), 32'(phase == M_LOAD));
    chk({tag, ".valid"}, 32'(Batch_Valid), 32'(phase == M_DONE));
    chk({tag, ".state"}, 32'({Qd, Qc, Ql}), 32'(qs));
    chk({tag, ".red_in"}, 32'(red_in), 32'(m_red));
    chk({tag, ".green_in"}, 32'(green_in), 32'(m_green));
    chk({tag, ".blue_in"}, 32'(blue_in), 32'(m_blue));
    chk({tag, ".red_exp"}, 32'(red_exp), 32'(me_r));
    chk({tag, ".green_exp"}, 32'(green_exp), 32'(me_g));
    chk({tag, ".blue_exp"}, 32'(blue_exp), 32'(me_b));
  endtask

  task automatic cycle(input logic pv, input logic [7:0] r, g, b, input logic ack,
                       input string tag);
    Pix_Valid = pv; Pix_R = r; Pix_G = g; Pix_B = b; Batch_Ack = ack;
    @(posedge Clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic send(input logic [7:0] r, g, b, input string tag);
    cycle(1'b1, r, g, b, 1'b0, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, tag);
  endtask

  task automatic ack(input string tag);
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, tag);
  endtask

  task automatic chk_spec_batch(input string tag);
    chk({tag, ".red_in"}, 32'(red_in), 32'h3D3D3DCC);
    chk({tag, ".green_in"}, 32'(green_in), 32'h85858500);
    chk({tag, ".blue_in"}, 32'(blue_in), 32'hC6C6C600);
    chk({tag, ".red_exp"}, 32'(red_exp), 32'd96);
    chk({tag, ".green_exp"}, 32'(green_exp), 32'd99);
    chk({tag, ".blue_exp"}, 32'(blue_exp), 32'd148);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    Pix_Valid = 1'b0; Batch_Ack = 1'b0;
    model_reset();
    @(posedge Clk);
    #1;
    check_model("reset");
    Reset = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'd204, 8'd0,   8'd0,   1'b0, 1'b1, 1'b0, 3'b001};
    tbl[1] = '{1'b1, 8'd61,  8'd133, 8'd198, 1'b0, 1'b1, 1'b0, 3'b001};
    tbl[2] = '{1'b1, 8'd61,  8'd133, 8'd198, 1'b0, 1'b1, 1'b0, 3'b001};
    tbl[3] = '{1'b1, 8'd61,  8'd133, 8'd198, 1'b0, 1'b0, 1'b0, 3'b010};
    tbl[4] = '{1'b1, 8'd61,  8'd133, 8'd198, 1'b0, 1'b0, 1'b1, 3'b100};
    tbl[5] = '{1'b0, 8'd0,   8'd0,   8'd0,   1'b0, 1'b0, 1'b1, 3'b100};
    tbl[6] = '{1'b0, 8'd0,   8'd0,   8'd0,   1'b1, 1'b1, 1'b0, 3'b001};

    do_reset();
    chk("reset.red_in_zero", 32'(red_in), 32'h0);
    chk("reset.exp_zero", 32'({red_exp, green_exp, blue_exp}), 32'h0);

    // First batch from the vector table
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].pv, tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].ack, "tbl");
      chk($sformatf("tbl%0d.ready", i), 32'(Pix_Ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d.valid", i), 32'(Batch_Valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d.state", i), 32'({Qd, Qc, Ql}), 32'(tbl[i].q));
      if (i == 5) chk_spec_batch("tbl");
    end

    // Same stream with a 3-cycle bubble between pixels 1 and 2
    send(8'd204, 8'd0, 8'd0, "gap");
    idle(3, "gap.bubble");
    chk("gap.ready_in_bubble", 32'(Pix_Ready), 32'd1);
    for (int i = 0; i < 3; i++) send(8'd61, 8'd133, 8'd198, "gap");
    idle(2, "gap.tail");
    chk_spec_batch("gap");

    // Hold in QD with new data offered; nothing may be accepted
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'h11, 8'h22, 8'h33, 1'b0, "hold");
    chk_spec_batch("hold");
    cycle(1'b1, 8'h11, 8'h22, 8'h33, 1'b1, "hold.ack");
    chk("hold.ack_ql", 32'(Ql), 32'd1);
    send(8'h11, 8'h22, 8'h33, "hold.next");
    chk("hold.lane0", 32'({red_in[7:0], green_in[7:0], blue_in[7:0]}), 32'h112233);
    chk("hold.lane1_kept", 32'(red_in[15:8]), 32'd61);

    // Asynchronous reset mid-load
    send(8'h44, 8'h55, 8'h66, "abort");
    #2 Reset = 1'b0;
    #1;
    chk("areset.red_in", 32'(red_in), 32'h0);
    chk("areset.blue_in", 32'(blue_in), 32'h0);
    chk("areset.exp", 32'({red_exp, green_exp, blue_exp}), 32'h0);
    chk("areset.state", 32'({Qd, Qc, Ql, Batch_Valid, Pix_Ready}), 32'b00101);
    model_reset();
    @(posedge Clk);
    #1 Reset = 1'b1;
    send(8'd204, 8'd0, 8'd0, "post_reset");
    for (int i = 0; i < 3; i++) send(8'd61, 8'd133, 8'd198, "post_reset");
    idle(2, "post_reset");
    chk_spec_batch("post_reset");
    ack("post_reset.ack");

    // Saturated batch then zero batch: sums must clear between batches
    for (int i = 0; i < NP; i++) send(8'hFF, 8'hFF, 8'hFF, "max");
    idle(2, "max");
    chk("max.exp", 32'({red_exp, green_exp, blue_exp}), 32'hFFFFFF);
    ack("max.ack");
    for (int i = 0; i < NP; i++) send(8'h00, 8'h00, 8'h00, "zero");
    idle(2, "zero");
    chk("zero.exp", 32'({red_exp, green_exp, blue_exp}), 32'h0);
    ack("zero.ack");

    // Batch_Ack pulse mid-load is ignored
    send(8'd10, 8'd20, 8'd30, "midack");
    send(8'd20, 8'd30, 8'd40, "midack");
    ack("midack.pulse");
    chk("midack.still_ql", 32'(Ql), 32'd1);
    send(8'd30, 8'd40, 8'd50, "midack");
    send(8'd40, 8'd50, 8'd60, "midack");
    idle(2, "midack");
    chk("midack.exp", 32'({red_exp, green_exp, blue_exp}), 32'h19232D);
    chk("midack.red_in", 32'(red_in), 32'h281E140A);
    ack("midack.ack");

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 2) == 0), "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
